sa_skew_feeder: RTL
===================

SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

Interface
REQ-001 Parameter N, default 4, number of array rows/lanes; legal range 1..16.
REQ-002 Parameter WIDTH, default 8, signed element width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin one operand stream; honoured only in IDLE.
REQ-006 s_valid  input  1  upstream vector valid.
REQ-007 s_ready  output  1  feeder accepts a vector this cycle.
REQ-008 s_data  input  N*WIDTH  one operand column; lane i at bits [i*WIDTH +: WIDTH].
REQ-009 s_last  input  1  qualifies the final vector of the stream.
REQ-010 a_out  output  N*WIDTH  skewed lanes driving the array's left-edge a_in ports.
REQ-011 en_out  output  1  array enable; high when a_out carries a new shifted value.
REQ-012 busy  output  1  high in LOAD or FLUSH.
REQ-013 done  output  1  single-cycle pulse at stream completion.

Function
REQ-014 FSM states IDLE, LOAD, FLUSH, DONE; IDLE->LOAD on start; LOAD->FLUSH on the cycle accepting s_last; FLUSH->DONE when flush count expires; DONE->IDLE unconditionally after one cycle.
REQ-015 s_ready is high only in LOAD; a vector is accepted when s_valid && s_ready.
REQ-016 Lane i uses a shift chain of i+1 registers; lane 0 has one register; all chains advance together on a shift cycle.
REQ-017 Shift cycle = acceptance cycle in LOAD, or any cycle in FLUSH; otherwise every chain holds.
REQ-018 In FLUSH, zero is injected into every lane's chain head.
REQ-019 Lane i of an accepted vector appears on a_out lane i exactly i+1 shift cycles after acceptance (skew i relative to lane 0).
REQ-020 en_out is registered: high in the cycle after a shift cycle, low otherwise; a_out is stable while en_out is low.
REQ-021 In LOAD with s_valid low, no shift occurs, en_out drops; the array is frozen, no bubble is inserted.
REQ-022 FLUSH lasts exactly 2*N-1 shift cycles, draining the skew and the array's horizontal pipeline; for N=1, FLUSH lasts 1 cycle.
REQ-023 done is high for exactly one cycle, in DONE state; busy is low in DONE and IDLE.
REQ-024 start asserted outside IDLE is ignored; start and s_valid in the same IDLE cycle accept no data.
REQ-025 A stream of one vector is legal: acceptance with s_last moves LOAD->FLUSH directly.
REQ-026 s_data, s_last are ignored when no acceptance occurs.

Reset
REQ-027 With rst high at a clock edge: state IDLE, all chain registers and a_out zero, en_out 0, s_ready 0, busy 0, done 0, flush counter 0.
REQ-028 Reset mid-LOAD or mid-FLUSH discards all in-flight data; no done pulse follows.

Configuration
REQ-029 Macro SA_SKEW_FEEDER_STALL_CNT_EN defined: adds output stall_cnt [15:0], counting LOAD cycles with s_valid low, cleared on start and reset, saturating at 16'hFFFF, held after DONE.
REQ-030 Macro undefined: no stall_cnt port and no counter logic; all other behaviour identical.

Verification
REQ-031 N=4: start, then 3 back-to-back vectors {lane0..3}={1,2,3,4},{5,6,7,8},{9,10,11,12} with last on the third -> lane0 shows 1,5,9 on consecutive cycles; lane3 shows 4 three cycles after lane0 shows 1; en_out high 3+7 cycles; done pulses once.
REQ-032 Same stream with s_valid low 2 cycles between vectors 1 and 2 -> en_out low 2 cycles, a_out holds, skew relationships unchanged; stall_cnt=2 with macro.
REQ-033 Single vector {-128,127,-1,0} with last -> values appear signed-exact on lanes 0..3 at skew 1..4, followed by zeros; done after 7 FLUSH cycles.
REQ-034 Assert rst during FLUSH -> next cycle all outputs zero, state IDLE, no done; new start runs a clean stream.
REQ-035 start pulsed during LOAD and DONE -> ignored; s_valid in IDLE -> s_ready 0, no data captured.
REQ-036 N=1: one vector {7} with last -> a_out=7 with en_out one cycle after acceptance, FLUSH 1 cycle, done pulse.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// Skewed operand feeder for the left edge of an N-row systolic array: lane i is delayed i cycles relative to lane 0.
// Optional stall counter output enabled by defining SA_SKEW_FEEDER_STALL_CNT_EN.
module sa_skew_feeder #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N*WIDTH-1:0]   s_data,
    input  logic                 s_last,
    output logic [N*WIDTH-1:0]   a_out,
    output logic                 en_out,
    output logic                 busy,
`ifdef SA_SKEW_FEEDER_STALL_CNT_EN
    output logic [15:0]          stall_cnt,
`endif
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            en_reg;
    logic            accept;
    logic            shift;

    assign s_ready = (state_reg == LOAD);
    assign accept  = s_valid && s_ready;
    assign shift   = accept || (state_reg == FLUSH);
    assign busy    = (state_reg == LOAD) || (state_reg == FLUSH);
    assign done    = (state_reg == DONE);
    assign en_out  = en_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            en_reg    <= shift;
        end
    end

    // The flush counter is preloaded with 2N-2 so the FLUSH state spans 2N-1 cycles.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (accept && s_last) begin
                    state_next = FLUSH;
                    cnt_next   = FLUSH_LAST;
                end
            end
            FLUSH: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [WIDTH-1:0] chain_reg [0:gi];
            logic [WIDTH-1:0] head;

            // Zeros are pushed in while flushing so the array drains cleanly.
            assign head = (state_reg == FLUSH) ? '0 : s_data[gi*WIDTH +: WIDTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j <= gi; j++) begin
                        chain_reg[j] <= '0;
                    end
                end else if (shift) begin
                    chain_reg[0] <= head;
                    for (int j = 1; j <= gi; j++) begin
                        chain_reg[j] <= chain_reg[j-1];
                    end
                end
            end

            assign a_out[gi*WIDTH +: WIDTH] = chain_reg[gi];
        end
    endgenerate

`ifdef SA_SKEW_FEEDER_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            stall_reg <= '0;
        end else if ((state_reg == LOAD) && !s_valid && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_reg;
`endif

endmodule
